rv_multicycle_ctrl: RTL

Multicycle control FSM that sequences the RV32 datapath: instruction fetch, decode, execute, memory access and register writeback over several cycles. It replaces ad-hoc per-cycle opcode decode with one explicit state machine. It drives every datapath enable and mux select, and it waits on a ready handshake from the shared memory port. It sits beside the register file, ALU, immediate generator and memory units in the core top level.

---
 rtl/rv_ctrl_pkg.sv | 62 ++++++
 rtl/rv_alu_decode.sv | 49 ++++
 rtl/rv_multicycle_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32 multicycle control path.
// Contents: FSM state encoding, instruction classes, opcode constants,
// ALU control codes, pc_src / wb_sel encodings and an opcode classifier.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_NONE   = 3'd7
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Map a 7-bit opcode onto the supported instruction classes.
  function automatic instr_class_t classify(input logic [6:0] op);
    instr_class_t c;
    case (op)
      OP_R:      c = CLS_R;
      OP_I:      c = CLS_I;
      OP_LOAD:   c = CLS_LOAD;
      OP_STORE:  c = CLS_STORE;
      OP_BRANCH: c = CLS_BRANCH;
      OP_JAL:    c = CLS_JAL;
      default:   c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational ALU-control decoder.
// Ports:
//   cls      in  3  instruction class (instr_class_t encoding)
//   funct3   in  3  IR[14:12]
//   funct7_5 in  1  IR[30], selects SUB for R-type funct3 000
//   alu_ctrl out 4  ALU operation code
//   legal    out 1  class/funct3 combination is supported
module rv_alu_decode
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  // Decode the ALU operation and flag unsupported funct3 values.
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000: begin
            if (cls == CLS_R && funct7_5) begin
              alu_ctrl = ALU_SUB;
            end else begin
              alu_ctrl = ALU_ADD;
            end
          end
          3'b100:  alu_ctrl = ALU_XOR;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          3'b010:  alu_ctrl = ALU_SLT;
          default: legal    = 1'b0;
        endcase
      end
      CLS_LOAD, CLS_STORE, CLS_JAL: alu_ctrl = ALU_ADD;
      CLS_BRANCH: begin
        // Only BEQ (000) and BNE (001) are supported.
        alu_ctrl = ALU_SUB;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Drives all datapath enables/selects and waits on the memory ready handshake.
// Ports:
//   clock, reset                   clock and synchronous active-high reset
//   opcode, funct3, funct7_5       instruction fields from the IR
//   zero                           live ALU zero flag (branch resolution)
//   mem_ready                      memory completes the current request
//   mem_req, mem_we, mem_is_data   memory request controls
//   ir_write, pc_write, pc_src     IR / PC update controls
//   alu_src_b, alu_ctrl            ALU operand select and operation
//   reg_wr_en, wb_sel              register writeback controls
//   illegal_instr, mem_timeout     sticky error flags
//   state_dbg                      current state encoding
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [1:0] RESET_PC_SEL   = 2'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_data,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       reg_wr_en,
  output logic [1:0] wb_sel,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [2:0] state_dbg
);

  state_t       state, state_next;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic [3:0]   alu_q;
  logic [3:0]   dec_alu;
  logic         dec_legal;
  logic         br_ne_q;
  // High for the first cycle after reset; the FSM sits idle in FETCH with
  // all outputs quiet so a fetch restarts one cycle after reset deasserts.
  logic         in_reset;
  logic [7:0]   wait_cnt;
  logic         illegal_q;
  logic         timeout_q;
  logic         waiting;
  logic         limit;

  assign dec_cls = classify(opcode);

  rv_alu_decode u_alu_decode (
    .cls      (dec_cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  // A wait cycle is one with an outstanding request that memory did not accept.
  assign waiting = !in_reset && ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  // Limit hits on the TIMEOUT_CYCLES-th consecutive wait cycle; mem_ready in
  // that same cycle keeps waiting low, so the transfer wins.
  assign limit   = waiting && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  assign alu_ctrl      = alu_q;
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;
  assign state_dbg     = state;

  // State register, latched decode, wait counter and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_FETCH;
      in_reset  <= 1'b1;
      cls_q     <= CLS_NONE;
      alu_q     <= 4'b0000;
      br_ne_q   <= 1'b0;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      in_reset <= 1'b0;
      state    <= state_next;
      if (state == ST_DECODE) begin
        cls_q   <= dec_cls;
        alu_q   <= dec_alu;
        br_ne_q <= funct3[0];
        if (!dec_legal) begin
          illegal_q <= 1'b1;
        end
      end
      if (limit) begin
        timeout_q <= 1'b1;
      end
      if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Next-state and Moore outputs (branch pc_write uses the live zero flag).
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_PLUS4;
    alu_src_b   = 1'b0;
    reg_wr_en   = 1'b0;
    wb_sel      = WB_ALU;
    if (in_reset) begin
      state_next = ST_FETCH;
      pc_src     = RESET_PC_SEL;
    end else begin
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          if (mem_ready) begin
            state_next = ST_DECODE;
          end else if (limit) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            state_next = ST_EXEC;
          end else begin
            state_next = ST_HALT;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_R: state_next = ST_WB;
            CLS_I: begin
              alu_src_b  = 1'b1;
              state_next = ST_WB;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src_b  = 1'b1;
              state_next = ST_MEM;
            end
            CLS_BRANCH: begin
              pc_write   = br_ne_q ? !zero : zero;
              pc_src     = PC_SRC_BRANCH;
              state_next = ST_FETCH;
            end
            CLS_JAL: begin
              pc_write   = 1'b1;
              pc_src     = PC_SRC_BRANCH;
              reg_wr_en  = 1'b1;
              wb_sel     = WB_PC4;
              state_next = ST_FETCH;
            end
            default: state_next = ST_HALT;
          endcase
        end
        ST_MEM: begin
          mem_req     = 1'b1;
          mem_is_data = 1'b1;
          mem_we      = (cls_q == CLS_STORE);
          if (mem_ready) begin
            state_next = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (limit) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_MEM;
          end
        end
        ST_WB: begin
          reg_wr_en  = 1'b1;
          wb_sel     = (cls_q == CLS_LOAD) ? WB_MEM : WB_ALU;
          state_next = ST_FETCH;
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_HALT;
      endcase
    end
  end

endmodule
